// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RV32 pipeline hazard controller: FSM states,
// forwarding selects and the x0 register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A producer only forwards if it really writes a non-x0 register matching the source.
    function automatic logic fwd_match(input logic i_wr, input logic [4:0] i_rd,
                                       input logic [4:0] i_src);
        return i_wr && (i_rd != REG_X0) && (i_rd == i_src);
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational operand and store-data forwarding selects.
// The memory stage has priority over writeback because it holds the younger result.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1_addr_E,
    input  logic [4:0] i_rs2_addr_E,
    input  logic [4:0] i_rd_M,
    input  logic       i_reg_wr_M,
    input  logic       i_mem_wr_M,
    input  logic [4:0] i_rs2_addr_M,
    input  logic [4:0] i_rd_W,
    input  logic       i_reg_wr_W,
    output fwd_sel_e   o_fwd_a_E,
    output fwd_sel_e   o_fwd_b_E,
    output logic       o_fwd_st_M
);

    always_comb begin
        o_fwd_a_E = FWD_RF;
        if (fwd_match(i_reg_wr_M, i_rd_M, i_rs1_addr_E))
            o_fwd_a_E = FWD_M;
        else if (fwd_match(i_reg_wr_W, i_rd_W, i_rs1_addr_E))
            o_fwd_a_E = FWD_W;
    end

    always_comb begin
        o_fwd_b_E = FWD_RF;
        if (fwd_match(i_reg_wr_M, i_rd_M, i_rs2_addr_E))
            o_fwd_b_E = FWD_M;
        else if (fwd_match(i_reg_wr_W, i_rd_W, i_rs2_addr_E))
            o_fwd_b_E = FWD_W;
    end

    assign o_fwd_st_M = i_mem_wr_M && fwd_match(i_reg_wr_W, i_rd_W, i_rs2_addr_M);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: stall/flush, forwarding,
// dmem wait-state FSM with timeout. Optional perf counters under HAZ_PERF_CNT_EN.
//   state    | meaning
//   RUN      | normal flow, no outstanding un-acked access
//   MEM_WAIT | dmem access pending, counting un-acked cycles
//   TIMEOUT  | one-cycle kill of the hung access
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_rs1_addr_D,
    input  logic [4:0]       i_rs2_addr_D,
    input  logic [4:0]       i_rs1_addr_E,
    input  logic [4:0]       i_rs2_addr_E,
    input  logic [4:0]       i_rd_E,
    input  logic             i_reg_wr_E,
    input  logic             i_mem_rd_E,
    input  logic             i_branch_taken_E,
    input  logic [4:0]       i_rd_M,
    input  logic             i_reg_wr_M,
    input  logic             i_mem_rd_M,
    input  logic             i_mem_wr_M,
    input  logic [4:0]       i_rs2_addr_M,
    input  logic [4:0]       i_rd_W,
    input  logic             i_reg_wr_W,
    input  logic             i_dmem_ack,
    output logic             o_stall_F,
    output logic             o_stall_D,
    output logic             o_stall_E,
    output logic             o_stall_M,
    output logic             o_flush_D,
    output logic             o_flush_E,
    output logic             o_flush_M,
    output logic             o_flush_W,
    output logic [1:0]       o_fwd_a_E,
    output logic [1:0]       o_fwd_b_E,
    output logic             o_fwd_st_M,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_perf_stall_cnt,
    output logic [CNT_W-1:0] o_perf_flush_cnt
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    hz_state_e     r_state, w_state_nxt;
    logic [CW-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic          w_mem_act, w_mwait, w_load_use;
    fwd_sel_e      w_fwd_a, w_fwd_b;
    logic          w_fwd_st;
    logic          w_unused_reg_wr_E;

    // Loads always write a register, so the E-stage write enable adds nothing to load-use.
    assign w_unused_reg_wr_E = i_reg_wr_E;

    assign w_mem_act  = i_mem_rd_M | i_mem_wr_M;
    assign w_mwait    = w_mem_act & ~i_dmem_ack;
    assign w_load_use = i_mem_rd_E && (i_rd_E != REG_X0) &&
                        ((i_rd_E == i_rs1_addr_D) || (i_rd_E == i_rs2_addr_D));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (w_mwait) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (i_dmem_ack) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt    = TIMEOUT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        o_stall_F     = 1'b0;
        o_stall_D     = 1'b0;
        o_stall_E     = 1'b0;
        o_stall_M     = 1'b0;
        o_flush_D     = 1'b0;
        o_flush_E     = 1'b0;
        o_flush_M     = 1'b0;
        o_flush_W     = 1'b0;
        o_mem_timeout = 1'b0;
        if (!i_rst) begin
            if (r_state == TIMEOUT) begin
                o_mem_timeout = 1'b1;
                o_stall_F     = 1'b1;
                o_stall_D     = 1'b1;
                o_stall_E     = 1'b1;
                o_flush_M     = 1'b1;
                o_flush_W     = 1'b1;
            end else if (w_mwait) begin
                // E is frozen, so a taken branch there is simply re-seen after the ack.
                o_stall_F = 1'b1;
                o_stall_D = 1'b1;
                o_stall_E = 1'b1;
                o_stall_M = 1'b1;
                o_flush_W = 1'b1;
            end else if (i_branch_taken_E) begin
                o_flush_D = 1'b1;
                o_flush_E = 1'b1;
            end else if (w_load_use) begin
                o_stall_F = 1'b1;
                o_stall_D = 1'b1;
                o_flush_E = 1'b1;
            end
        end
    end

    pipe_fwd_unit u_fwd (
        .i_rs1_addr_E (i_rs1_addr_E),
        .i_rs2_addr_E (i_rs2_addr_E),
        .i_rd_M       (i_rd_M),
        .i_reg_wr_M   (i_reg_wr_M),
        .i_mem_wr_M   (i_mem_wr_M),
        .i_rs2_addr_M (i_rs2_addr_M),
        .i_rd_W       (i_rd_W),
        .i_reg_wr_W   (i_reg_wr_W),
        .o_fwd_a_E    (w_fwd_a),
        .o_fwd_b_E    (w_fwd_b),
        .o_fwd_st_M   (w_fwd_st)
    );

    assign o_fwd_a_E  = i_rst ? 2'b00 : w_fwd_a;
    assign o_fwd_b_E  = i_rst ? 2'b00 : w_fwd_b;
    assign o_fwd_st_M = ~i_rst & w_fwd_st;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_stall_F)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (o_flush_D | o_flush_E)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_perf_stall_cnt = i_rst ? '0 : r_stall_cnt;
    assign o_perf_flush_cnt = i_rst ? '0 : r_flush_cnt;
`else
    assign o_perf_stall_cnt = '0;
    assign o_perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MAX_WAIT=4): a rule-level model is checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [4:0]       rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_E, rd_M, rs2_addr_M, rd_W;
    logic             reg_wr_E, mem_rd_E, branch_taken_E, reg_wr_M, mem_rd_M, mem_wr_M, reg_wr_W, dmem_ack;
    logic             stall_F, stall_D, stall_E, stall_M;
    logic             flush_D, flush_E, flush_M, flush_W;
    logic [1:0]       fwd_a_E, fwd_b_E;
    logic             fwd_st_M, mem_timeout;
    logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addr_D(rs1_addr_D), .i_rs2_addr_D(rs2_addr_D),
        .i_rs1_addr_E(rs1_addr_E), .i_rs2_addr_E(rs2_addr_E),
        .i_rd_E(rd_E), .i_reg_wr_E(reg_wr_E), .i_mem_rd_E(mem_rd_E),
        .i_branch_taken_E(branch_taken_E),
        .i_rd_M(rd_M), .i_reg_wr_M(reg_wr_M), .i_mem_rd_M(mem_rd_M), .i_mem_wr_M(mem_wr_M),
        .i_rs2_addr_M(rs2_addr_M), .i_rd_W(rd_W), .i_reg_wr_W(reg_wr_W), .i_dmem_ack(dmem_ack),
        .o_stall_F(stall_F), .o_stall_D(stall_D), .o_stall_E(stall_E), .o_stall_M(stall_M),
        .o_flush_D(flush_D), .o_flush_E(flush_E), .o_flush_M(flush_M), .o_flush_W(flush_W),
        .o_fwd_a_E(fwd_a_E), .o_fwd_b_E(fwd_b_E), .o_fwd_st_M(fwd_st_M),
        .o_mem_timeout(mem_timeout),
        .o_perf_stall_cnt(perf_stall_cnt), .o_perf_flush_cnt(perf_flush_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: how many un-acked cycles in a row, and whether the kill cycle is due.
    int               miss_run = 0;
    bit               tmo_due  = 1'b0;
    logic [CNT_W-1:0] m_stall_cnt = '0;
    logic [CNT_W-1:0] m_flush_cnt = '0;

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (reg_wr_M && rd_M != 5'd0 && rd_M == src) return 2'b01;
        if (reg_wr_W && rd_W != 5'd0 && rd_W == src) return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        logic e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fW, e_to, e_st, waiting;
        logic [1:0] e_fa, e_fb;
        logic [CNT_W-1:0] e_pcs, e_pcf;
        {e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fW, e_to, e_st} = '0;
        e_fa = 2'b00;
        e_fb = 2'b00;
        waiting = (mem_rd_M || mem_wr_M) && !dmem_ack;
        if (!rst) begin
            if (tmo_due) begin
                {e_to, e_sF, e_sD, e_sE, e_fM, e_fW} = 6'b111111;
            end else if (waiting) begin
                {e_sF, e_sD, e_sE, e_sM, e_fW} = 5'b11111;
            end else if (branch_taken_E) begin
                {e_fD, e_fE} = 2'b11;
            end else if (mem_rd_E && rd_E != 5'd0 && (rd_E == rs1_addr_D || rd_E == rs2_addr_D)) begin
                {e_sF, e_sD, e_fE} = 3'b111;
            end
            e_fa = m_fwd(rs1_addr_E);
            e_fb = m_fwd(rs2_addr_E);
            e_st = mem_wr_M && reg_wr_W && rd_W != 5'd0 && rd_W == rs2_addr_M;
        end
`ifdef HAZ_PERF_CNT_EN
        e_pcs = rst ? '0 : m_stall_cnt;
        e_pcf = rst ? '0 : m_flush_cnt;
`else
        e_pcs = '0;
        e_pcf = '0;
`endif
        chk("m_stall_F", stall_F, e_sF);
        chk("m_stall_D", stall_D, e_sD);
        chk("m_stall_E", stall_E, e_sE);
        chk("m_stall_M", stall_M, e_sM);
        chk("m_flush_D", flush_D, e_fD);
        chk("m_flush_E", flush_E, e_fE);
        chk("m_flush_M", flush_M, e_fM);
        chk("m_flush_W", flush_W, e_fW);
        chk("m_fwd_a", fwd_a_E, e_fa);
        chk("m_fwd_b", fwd_b_E, e_fb);
        chk("m_fwd_st", fwd_st_M, e_st);
        chk("m_timeout", mem_timeout, e_to);
        chk("m_perf_stall", perf_stall_cnt, e_pcs);
        chk("m_perf_flush", perf_flush_cnt, e_pcf);
        if (rst) begin
            miss_run = 0;
            tmo_due  = 1'b0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else begin
            m_stall_cnt = m_stall_cnt + CNT_W'(e_sF);
            m_flush_cnt = m_flush_cnt + CNT_W'(e_fD | e_fE);
            if (tmo_due) begin
                tmo_due  = 1'b0;
                miss_run = 0;
            end else if (waiting) begin
                miss_run++;
                if (miss_run == MAX_WAIT) begin
                    tmo_due  = 1'b1;
                    miss_run = 0;
                end
            end else begin
                miss_run = 0;
            end
        end
    end

    task automatic clr();
        {rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_E, rd_M, rs2_addr_M, rd_W} = '0;
        {reg_wr_E, mem_rd_E, branch_taken_E, reg_wr_M, mem_rd_M, mem_wr_M, reg_wr_W, dmem_ack} = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        mem_rd_M = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_stall_F", stall_F, 0);
            chk("rst_flush_W", flush_W, 0);
            next_cycle();
        end
        rst = 1'b0;
        clr();
        @(negedge clk); chk("idle_stall_F", stall_F, 0); next_cycle();

        // load-use: one bubble, then the load result forwards from M
        mem_rd_E = 1; reg_wr_E = 1; rd_E = 5'd5; rs1_addr_D = 5'd5;
        @(negedge clk);
        chk("lu_stall_F", stall_F, 1); chk("lu_stall_D", stall_D, 1);
        chk("lu_flush_E", flush_E, 1); chk("lu_stall_E", stall_E, 0);
        next_cycle();
        clr();
        rd_M = 5'd5; reg_wr_M = 1; mem_rd_M = 1; dmem_ack = 1; rs1_addr_E = 5'd5; rs1_addr_D = 5'd5;
        @(negedge clk); chk("lu_fwd_a", fwd_a_E, 2'b01); chk("lu2_stall_F", stall_F, 0); next_cycle();

        // three wait states then ack
        clr(); mem_rd_M = 1; rd_M = 5'd6; reg_wr_M = 1;
        repeat (3) begin
            @(negedge clk);
            chk("mw_stall_M", stall_M, 1); chk("mw_flush_W", flush_W, 1); chk("mw_timeout", mem_timeout, 0);
            next_cycle();
        end
        dmem_ack = 1;
        @(negedge clk); chk("mw_ack_stall_M", stall_M, 0); chk("mw_ack_timeout", mem_timeout, 0); next_cycle();

        // never acked: four stalled cycles, then the timeout pulse
        clr(); mem_wr_M = 1;
        repeat (4) begin
            @(negedge clk); chk("to_stall_E", stall_E, 1); chk("to_early", mem_timeout, 0); next_cycle();
        end
        @(negedge clk);
        chk("to_pulse", mem_timeout, 1); chk("to_flush_M", flush_M, 1);
        chk("to_stall_M", stall_M, 0); chk("to_stall_F", stall_F, 1);
        next_cycle();
        clr();
        @(negedge clk); chk("to_after", mem_timeout, 0); chk("to_after_stall", stall_F, 0); next_cycle();

        // branch beats load-use; mwait beats branch
        branch_taken_E = 1; mem_rd_E = 1; rd_E = 5'd3; rs2_addr_D = 5'd3;
        @(negedge clk);
        chk("br_flush_D", flush_D, 1); chk("br_flush_E", flush_E, 1); chk("br_stall_F", stall_F, 0);
        next_cycle();
        mem_rd_M = 1;
        repeat (2) begin
            @(negedge clk); chk("brw_flush_D", flush_D, 0); chk("brw_stall_F", stall_F, 1); next_cycle();
        end
        dmem_ack = 1;
        @(negedge clk); chk("brw_ack_flush_D", flush_D, 1); chk("brw_ack_stall_F", stall_F, 0); next_cycle();

        // forwarding priority and x0 suppression
        clr(); rd_M = 5'd7; rd_W = 5'd7; reg_wr_M = 1; reg_wr_W = 1; rs1_addr_E = 5'd7; rs2_addr_E = 5'd7;
        @(negedge clk); chk("fwd_a_M", fwd_a_E, 2'b01); chk("fwd_b_M", fwd_b_E, 2'b01); next_cycle();
        rd_M = 5'd0;
        @(negedge clk); chk("fwd_a_W", fwd_a_E, 2'b10); next_cycle();
        mem_wr_M = 1; dmem_ack = 1; rs2_addr_M = 5'd7;
        @(negedge clk); chk("fwd_st", fwd_st_M, 1); next_cycle();
        rd_W = 5'd0; rs2_addr_M = 5'd0; rs1_addr_E = 5'd0;
        @(negedge clk); chk("fwd_st_x0", fwd_st_M, 0); chk("fwd_a_x0", fwd_a_E, 2'b00); next_cycle();

        // reset in the middle of a wait drops the access and clears the wait count
        clr(); mem_rd_M = 1;
        repeat (2) next_cycle();
        rst = 1;
        @(negedge clk);
        chk("rstw_stall_M", stall_M, 0); chk("rstw_flush_W", flush_W, 0);
`ifdef HAZ_PERF_CNT_EN
        chk("rstw_perf_stall", perf_stall_cnt, 0); chk("rstw_perf_flush", perf_flush_cnt, 0);
`endif
        next_cycle();
        rst = 0;
        repeat (4) begin
            @(negedge clk); chk("rstw_stall_M", stall_M, 1); chk("rstw_no_to", mem_timeout, 0); next_cycle();
        end
        @(negedge clk); chk("rstw_timeout", mem_timeout, 1); next_cycle();
        clr();

        // mixed traffic with zero-wait memory; the model checks every cycle
        for (int i = 0; i < 30; i++) begin
            rs1_addr_D = 5'($urandom_range(0, 3)); rs2_addr_D = 5'($urandom_range(0, 3));
            rs1_addr_E = 5'($urandom_range(0, 3)); rs2_addr_E = 5'($urandom_range(0, 3));
            rd_E = 5'($urandom_range(0, 3)); rd_M = 5'($urandom_range(0, 3));
            rd_W = 5'($urandom_range(0, 3)); rs2_addr_M = 5'($urandom_range(0, 3));
            reg_wr_E = 1'($urandom); mem_rd_E = 1'($urandom); branch_taken_E = 1'($urandom);
            reg_wr_M = 1'($urandom); reg_wr_W = 1'($urandom);
            mem_rd_M = 1'($urandom); mem_wr_M = 1'($urandom); dmem_ack = 1'b1;
            next_cycle();
        end
        clr();
        repeat (2) next_cycle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
